rca32_multiword_add_seq: RTL
============================

# rca32_multiword_add_seq

Sequencer that performs WORDS×32-bit unsigned addition by time-multiplexing a single 32-bit ripple-carry adder (xnor_based_ripple_carry_adder32, no carry-in, 33-bit result). It accepts one operand pair per transaction over a valid/ready handshake, walks the words LSB-first, and injects inter-word carries with an extra adder pass. It then returns the (WORDS×32+1)-bit sum. It sits between the datapath front end and the obfuscated adder macro, which stays untouched.

## Interface
- WORDS, 4, number of 32-bit words per operand (≥1)
- CNT_W, $clog2(WORDS)+1, word-index counter width
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid_i  input  1  operand pair available
- in_ready_o  output  1  sequencer idle, can accept
- op_a_i  input  WORDS*32  operand A
- op_b_i  input  WORDS*32  operand B
- out_valid_o  output  1  result held and valid
- out_ready_i  input  1  consumer takes result
- sum_o  output  WORDS*32+1  result; MSB is the final carry
- busy_o  output  1  FSM in ADD or INC

## Operation
- FSM states: IDLE, ADD, INC, DONE. The state encoding is a package enum.
- IDLE: in_ready_o=1. On in_valid_i&&in_ready_o, latch op_a_i/op_b_i, clear the sum register, carry=0, idx=0, then go to ADD.
- ADD: adder inputs = A[idx], B[idx]. Capture r=result_o[31:0] into partial and c1=result_o[32].
  - If carry==0: write partial to sum[idx], set carry=c1, and advance.
  - If carry==1: store partial and c1, then go to INC.
- INC: adder inputs = partial, 32'd1. Write result_o[31:0] to sum[idx]. Set carry = c1 | result_o[32]; c1 and result_o[32] are never both 1. Then advance.
- Advance: if idx==WORDS-1, set sum[WORDS*32]=carry and go to DONE. Otherwise idx++ and go to ADD.
- DONE: out_valid_o=1 and sum_o stable. On out_ready_i, go to IDLE, and in_ready_o rises the next cycle. No new transaction is accepted in DONE.
- Operands are captured at accept. Later changes on op_a_i/op_b_i have no effect.
- Adder inputs are driven from registered muxes only, so there are no comb loops through the adder.
- The adder output is used the same cycle (single-cycle combinational path). There is no multicycle constraint.

## Timing
- Reset values: in_ready_o=1, out_valid_o=0, busy_o=0, sum_o=0, state=IDLE, idx=0, carry=0.
- Latency from accept edge to out_valid_o high = WORDS + K cycles. K is the number of words entered with carry=1, and K ranges from 0 to WORDS-1.
- Word 0 never enters INC.
- Throughput: at most one transaction per WORDS+K+2 cycles (accept, compute, DONE handshake).
- out_valid_o stays high until out_ready_i. Backpressure holds sum_o indefinitely.
- in_valid_i is ignored outside IDLE.
- Async reset mid-ADD/INC/DONE: all outputs return to their reset values immediately. The in-flight transaction is lost and no partial out_valid_o is emitted.
- WORDS=1: ADD goes straight to DONE, so latency is 1 and the MSB is the adder carry.
- Wrap-around: an all-ones + 1 carry ripples through every word, giving K=WORDS-1 and sum_o = 1<<(WORDS*32).

## Structure
- Package rca_seq_pkg holds:
  - the state enum (IDLE/ADD/INC/DONE)
  - the word-width constant WORD_W=32
  - the function that computes the cycle count from operands, for the bench scoreboard.
- One sub-module instance: xnor_based_ripple_carry_adder32 (add1_i, add2_i, result_o), used unmodified.
- Word select uses an indexed part-select on the latched operand registers. The sum register is written per word.

## Test plan
- WORDS=4, A=1, B=2 → sum_o=3, MSB 0, out_valid_o 4 cycles after accept (K=0).
- A=32'hFFFF_FFFF in every word, B=1 → sum_o = 129'h1_0000…0, latency 4+3=7 cycles, INC visited on words 1–3.
- A=B=all-ones (128 bits) → sum_o = {1'b1, 128'hFFFF…FFFE}, K=3.
- Hold out_ready_i low for 10 cycles in DONE → sum_o stable, in_ready_o=0, a new in_valid_i is ignored. After release, a back-to-back transaction is accepted on the cycle after IDLE is re-entered.
- Assert rst during INC of word 2 → out_valid_o stays 0, sum_o=0, in_ready_o=1 asynchronously. A fresh transaction afterwards completes correctly.
- Random 2000 pairs vs a 129-bit reference model → sum and per-transaction latency match the package cycle-count function.

Source files
------------

// File: rtl/rca32_multiword_add_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rca_seq_pkg
// Description : Shared types and constants for the multi-word add sequencer.
//               Provides the FSM state enum, the word width, and a helper
//               function that predicts transaction latency from operands.
// Revision    : 1.0 - initial release
// ============================================================================
package rca_seq_pkg;

  localparam int WORD_W    = 32;
  // Upper bound on operand words accepted by cycle_count().
  localparam int MAX_WORDS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    INC  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  // Cycles from the accept edge to out_valid: one ADD pass per word plus one
  // INC pass for every word entered with an incoming carry.
  function automatic int unsigned cycle_count(
    input logic [MAX_WORDS*WORD_W-1:0] a,
    input logic [MAX_WORDS*WORD_W-1:0] b,
    input int unsigned                 words
  );
    logic          carry;
    logic [WORD_W:0] s;
    int unsigned   k;
    carry = 1'b0;
    k     = 0;
    for (int i = 0; i < int'(words); i++) begin
      if (carry) k++;
      s = {1'b0, a[i*WORD_W +: WORD_W]} + {1'b0, b[i*WORD_W +: WORD_W]}
        + {{WORD_W{1'b0}}, carry};
      carry = s[WORD_W];
    end
    return words + k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rca32_multiword_add_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : rca32_multiword_add_seq_if
// Description : Handshake/bus bundle of the multi-word add sequencer.
//               Ports: in_valid_i/in_ready_o/op_a_i/op_b_i (operand channel),
//               out_valid_o/out_ready_i/sum_o (result channel), busy_o.
//               master = producer/consumer side, slave = sequencer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface rca32_multiword_add_seq_if
  import rca_seq_pkg::*;
#(
  parameter int WORDS = 4
);

  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [WORDS*WORD_W-1:0] op_a_i;
  logic [WORDS*WORD_W-1:0] op_b_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [WORDS*WORD_W:0]   sum_o;
  logic                    busy_o;

  modport master (
    output in_valid_i, op_a_i, op_b_i, out_ready_i,
    input  in_ready_o, out_valid_o, sum_o, busy_o
  );

  modport slave (
    input  in_valid_i, op_a_i, op_b_i, out_ready_i,
    output in_ready_o, out_valid_o, sum_o, busy_o
  );

endinterface
`default_nettype wire

// File: rtl/xnor_based_ripple_carry_adder32.sv
`default_nettype none
// ============================================================================
// Module      : xnor_based_ripple_carry_adder32
// Description : 32-bit ripple-carry adder, no carry-in, 33-bit result.
//               Sum bits are built from two cascaded XNOR stages.
//               Ports: add1_i[31:0], add2_i[31:0] -> result_o[32:0].
// Revision    : 1.0 - initial release
// ============================================================================
module xnor_based_ripple_carry_adder32 (
  input  wire logic [31:0] add1_i,
  input  wire logic [31:0] add2_i,
  output logic      [32:0] result_o
);

  logic [32:0] w_c;

  assign w_c[0] = 1'b0;

  generate
    for (genvar i = 0; i < 32; i++) begin : g_bit
      logic w_x;
      // xnor(xnor(a,b),c) == a^b^c
      assign w_x         = ~(add1_i[i] ^ add2_i[i]);
      assign result_o[i] = ~(w_x ^ w_c[i]);
      assign w_c[i+1]    = (add1_i[i] & add2_i[i]) | (w_c[i] & ~w_x);
    end
  endgenerate

  assign result_o[32] = w_c[32];

endmodule
`default_nettype wire

// File: rtl/rca32_multiword_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : rca32_multiword_add_seq
// Description : WORDS x 32-bit unsigned adder that time-multiplexes a single
//               32-bit ripple-carry adder, LSB word first. An incoming carry
//               is added in a separate INC pass (partial + 1).
//               Ports: clk, rst (async, active-high), bus (slave modport:
//               operand valid/ready, result valid/ready, sum_o, busy_o).
// Revision    : 1.0 - initial release
// ============================================================================
module rca32_multiword_add_seq
  import rca_seq_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int CNT_W = $clog2(WORDS) + 1
) (
  input wire logic               clk,
  input wire logic               rst,
  rca32_multiword_add_seq_if.slave bus
);

  seq_state_e              state_q, state_d;
  logic [CNT_W-1:0]        idx_q;
  logic                    carry_q, carry_d;
  logic                    c1_q;
  logic [WORD_W-1:0]       partial_q;
  logic [WORDS*WORD_W-1:0] a_q, b_q;
  logic [WORDS*WORD_W:0]   sum_q;

  logic                    w_accept;
  logic                    w_last;
  logic                    w_wr_en;
  logic                    w_adv;
  logic [WORD_W-1:0]       w_add1, w_add2;
  logic [WORD_W:0]         w_res;

  assign w_accept = (state_q == IDLE) && bus.in_valid_i;
  assign w_last   = (idx_q == CNT_W'(WORDS - 1));

  // Adder operands come only from registers, so no loop closes through it.
  assign w_add1 = (state_q == INC) ? partial_q : a_q[WORD_W*int'(idx_q) +: WORD_W];
  assign w_add2 = (state_q == INC) ? WORD_W'(1) : b_q[WORD_W*int'(idx_q) +: WORD_W];

  xnor_based_ripple_carry_adder32 u_adder (
    .add1_i   (w_add1),
    .add2_i   (w_add2),
    .result_o (w_res)
  );

  // --------------------------------------------------------------------------
  // Next-state / control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    w_wr_en = 1'b0;
    w_adv   = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          state_d = ADD;
          carry_d = 1'b0;
        end
      end
      ADD: begin
        if (!carry_q) begin
          w_wr_en = 1'b1;
          carry_d = w_res[WORD_W];
          w_adv   = 1'b1;
        end else begin
          state_d = INC;
        end
      end
      INC: begin
        // partial+1 only carries when partial is all-ones, which rules out c1.
        w_wr_en = 1'b1;
        carry_d = c1_q | w_res[WORD_W];
        w_adv   = 1'b1;
      end
      DONE: begin
        if (bus.out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (w_adv) state_d = w_last ? DONE : ADD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      carry_q   <= 1'b0;
      c1_q      <= 1'b0;
      partial_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
    end else begin
      carry_q <= carry_d;
      if (w_accept) begin
        a_q   <= bus.op_a_i;
        b_q   <= bus.op_b_i;
        sum_q <= '0;
        idx_q <= '0;
      end
      if (state_q == ADD && carry_q) begin
        partial_q <= w_res[WORD_W-1:0];
        c1_q      <= w_res[WORD_W];
      end
      if (w_wr_en) sum_q[WORD_W*int'(idx_q) +: WORD_W] <= w_res[WORD_W-1:0];
      if (w_adv) begin
        if (w_last) sum_q[WORDS*WORD_W] <= carry_d;
        else        idx_q <= idx_q + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready_o  = (state_q == IDLE);
  assign bus.out_valid_o = (state_q == DONE);
  assign bus.busy_o      = (state_q == ADD) || (state_q == INC);
  assign bus.sum_o       = sum_q;

endmodule
`default_nettype wire
